// File: rtl/spike_out_pktzr.sv
// Spike output packetizer: queues neuron spike events stamped {ts, core_id, nurn}
// and hands them to the local router port over valid/ready, flagging timestep completion.
module spike_out_pktzr #(
    parameter int NUM_NURNS          = 4,
    parameter int NURN_CNT_BIT_WIDTH = 2,
    parameter int CORE_ID_W          = 4,
    parameter int TS_W               = 4,
    parameter int FIFO_DEPTH         = 4,
    parameter int FIFO_AW            = 2,
    localparam int PKT_W             = TS_W + CORE_ID_W + NURN_CNT_BIT_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          tick_i,
    input  logic                          spk_vld_i,
    input  logic [NURN_CNT_BIT_WIDTH-1:0] spk_nurn_i,
    input  logic                          step_done_i,
    input  logic [CORE_ID_W-1:0]          core_id_i,
    output logic [PKT_W-1:0]              pkt_o,
    output logic                          pkt_vld_o,
    input  logic                          pkt_rdy_i,
    output logic                          done_o,
    output logic                          ovf_o,
    output logic                          err_o
);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [TS_W-1:0]       ts_q;
    logic [PKT_W-1:0]      mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]    wr_ptr, rd_ptr;
    logic [FIFO_AW:0]      cnt;

    logic                  push, pop_out, out_free, fifo_empty, fifo_full;
    logic                  bypass, fifo_pop, fifo_push, drop, queue_empty;
    logic                  nurn_bad;
    logic [31:0]           nurn_ext;
    logic [PKT_W-1:0]      entry;

    assign entry      = {ts_q, core_id_i, spk_nurn_i};
    assign push       = spk_vld_i && (state_q == COLLECT);
    assign pop_out    = pkt_vld_o && pkt_rdy_i;
    assign out_free   = !pkt_vld_o || pop_out;
    assign fifo_empty = (cnt == '0);
    assign fifo_full  = (cnt == (FIFO_AW+1)'(FIFO_DEPTH));
    // A spike skips the FIFO only when nothing older is waiting ahead of it.
    assign bypass     = push && out_free && fifo_empty;
    assign fifo_pop   = out_free && !fifo_empty;
    assign fifo_push  = push && !bypass && (!fifo_full || fifo_pop);
    assign drop       = push && !bypass && fifo_full && !fifo_pop;
    assign queue_empty = !pkt_vld_o && fifo_empty;
    assign done_o     = (state_q == DONE);

    assign nurn_ext   = 32'(spk_nurn_i);
    assign nurn_bad   = spk_vld_i && (nurn_ext >= 32'(NUM_NURNS));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick_i) state_d = COLLECT;
            COLLECT: begin
                if (tick_i)
                    state_d = COLLECT;
                else if (step_done_i)
                    state_d = (queue_empty && !spk_vld_i) ? DONE : DRAIN;
            end
            DRAIN: begin
                if (tick_i)
                    state_d = COLLECT;
                else if (queue_empty)
                    state_d = DONE;
            end
            DONE:    if (tick_i) state_d = COLLECT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            ts_q    <= '0;
            ovf_o   <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (tick_i)
                ts_q <= ts_q + 1'b1;
            if (drop)
                ovf_o <= 1'b1;
            if ((spk_vld_i && state_q != COLLECT) || nurn_bad ||
                (tick_i && (state_q == COLLECT || state_q == DRAIN)))
                err_o <= 1'b1;
        end
    end

    // Output register: refill from FIFO head on the accepting edge keeps 1 pkt/cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pkt_o     <= '0;
            pkt_vld_o <= 1'b0;
        end else if (fifo_pop) begin
            pkt_o     <= mem[rd_ptr];
            pkt_vld_o <= 1'b1;
        end else if (bypass) begin
            pkt_o     <= entry;
            pkt_vld_o <= 1'b1;
        end else if (pop_out) begin
            pkt_vld_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (fifo_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({fifo_push, fifo_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (fifo_push)
            mem[wr_ptr] <= entry;
    end

endmodule

// File: tb/tb_spike_out_pktzr.sv
// Bench for spike_out_pktzr: directed scenarios plus random traffic against a
// queue-based reference model that scores every cycle.
module tb_spike_out_pktzr;

    localparam int PKT_W = 10;
    localparam int CAP   = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             tick = 1'b0, spk_vld = 1'b0, step_done = 1'b0, pkt_rdy = 1'b0;
    logic [1:0]       spk_nurn = '0;
    logic [3:0]       core_id = 4'd5;
    logic [PKT_W-1:0] pkt;
    logic             pkt_vld, done, ovf, err;

    int total = 0;
    int bad   = 0;
    int acc_cnt = 0;

    spike_out_pktzr dut (
        .clk_i(clk), .rst_n_i(rst_n), .tick_i(tick), .spk_vld_i(spk_vld),
        .spk_nurn_i(spk_nurn), .step_done_i(step_done), .core_id_i(core_id),
        .pkt_o(pkt), .pkt_vld_o(pkt_vld), .pkt_rdy_i(pkt_rdy),
        .done_o(done), .ovf_o(ovf), .err_o(err)
    );

    always #5 clk = ~clk;

    // Reference model: one queue holds every spike not yet taken by the router.
    typedef enum int {P_IDLE, P_COLLECT, P_DRAIN, P_DONE} phase_t;
    logic [PKT_W-1:0] q[$];
    logic [3:0]       m_ts;
    phase_t           m_ph;
    logic             m_ovf, m_err;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_ts = '0; m_ph = P_IDLE; m_ovf = 1'b0; m_err = 1'b0;
        end else begin
            bit was_empty, acc, no_room;
            total++;
            if (pkt_vld !== (q.size() != 0)) begin
                bad++;
                $display("FAIL vld_track: got %b want %b", pkt_vld, q.size() != 0);
            end
            if (q.size() != 0) begin
                total++;
                if (pkt !== q[0]) begin
                    bad++;
                    $display("FAIL pkt_order: got %h want %h", pkt, q[0]);
                end
            end
            total++;
            if (ovf !== m_ovf || err !== m_err || done !== (m_ph == P_DONE)) begin
                bad++;
                $display("FAIL flags: got ovf=%b err=%b done=%b want ovf=%b err=%b done=%b",
                         ovf, err, done, m_ovf, m_err, m_ph == P_DONE);
            end
            was_empty = (q.size() == 0);
            acc       = !was_empty && pkt_rdy;
            no_room   = (q.size() == CAP) && !acc;
            if (acc) begin
                void'(q.pop_front());
                acc_cnt++;
            end
            if (spk_vld) begin
                if (m_ph != P_COLLECT) m_err = 1'b1;
                else if (no_room)      m_ovf = 1'b1;
                else                   q.push_back({m_ts, core_id, spk_nurn});
            end
            if (tick) begin
                if (m_ph == P_COLLECT || m_ph == P_DRAIN) m_err = 1'b1;
                m_ph = P_COLLECT;
                m_ts = m_ts + 4'd1;
            end else if (m_ph == P_COLLECT && step_done) begin
                m_ph = (was_empty && !spk_vld) ? P_DONE : P_DRAIN;
            end else if (m_ph == P_DRAIN && was_empty) begin
                m_ph = P_DONE;
            end
        end
    end

    task automatic step(input logic t, input logic s, input logic [1:0] n,
                        input logic sd, input logic r);
        tick = t; spk_vld = s; spk_nurn = n; step_done = sd; pkt_rdy = r;
        @(posedge clk); #1;
        tick = 0; spk_vld = 0; step_done = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick = 0; spk_vld = 0; step_done = 0; pkt_rdy = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_done(input string name, input logic r, input int budget);
        for (int k = 0; k < budget && !done; k++) step(0, 0, 2'd0, 0, r);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL %s_done_timeout: got %b want 1", name, done);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({pkt, pkt_vld, done, ovf, err} !== '0) begin
            bad++;
            $display("FAIL reset: got pkt=%h vld=%b done=%b ovf=%b err=%b want all 0",
                     pkt, pkt_vld, done, ovf, err);
        end
    endtask

    task automatic test_basic();
        core_id = 4'd5;
        step(1, 0, 2'd0, 0, 1);
        step(0, 1, 2'd2, 0, 1);
        total++;
        if (pkt_vld !== 1'b1 || pkt !== 10'h056) begin
            bad++;
            $display("FAIL basic_latency: got vld=%b pkt=%h want vld=1 pkt=056", pkt_vld, pkt);
        end
        step(0, 0, 2'd0, 1, 1);
        wait_done("basic", 1, 2);
    endtask

    task automatic test_overflow();
        int a0;
        do_reset();
        step(1, 0, 2'd0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 2'(i), 0, 0);
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_five: got %b want 0", ovf);
        end
        step(0, 1, 2'd3, 0, 0);
        total++;
        if (ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sixth: got %b want 1", ovf);
        end
        a0 = acc_cnt;
        step(0, 0, 2'd0, 1, 0);
        wait_done("ovf", 1, 12);
        total++;
        if (acc_cnt - a0 !== 5) begin
            bad++;
            $display("FAIL ovf_count: got %0d want 5", acc_cnt - a0);
        end
    endtask

    task automatic test_toggle();
        int a0;
        do_reset();
        step(1, 0, 2'd0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 2'(3 - i), 0, 0);
        a0 = acc_cnt;
        step(0, 0, 2'd0, 1, 0);
        for (int k = 0; k < 30 && !done; k++) step(0, 0, 2'd0, 0, 1'(k & 1));
        total++;
        if (done !== 1'b1 || acc_cnt - a0 !== 4) begin
            bad++;
            $display("FAIL toggle: got done=%b pkts=%0d want done=1 pkts=4", done, acc_cnt - a0);
        end
    endtask

    task automatic test_full_pushpop();
        int a0;
        do_reset();
        a0 = acc_cnt;
        step(1, 0, 2'd0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 2'(i + 1), 0, 0);
        step(0, 1, 2'd2, 0, 1);
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL full_pushpop_ovf: got %b want 0", ovf);
        end
        step(0, 0, 2'd0, 1, 1);
        wait_done("full", 1, 12);
        total++;
        if (acc_cnt - a0 !== 6) begin
            bad++;
            $display("FAIL full_pushpop_count: got %0d want 6", acc_cnt - a0);
        end
    endtask

    task automatic test_errors();
        int a0;
        do_reset();
        step(1, 0, 2'd0, 0, 1);
        step(0, 0, 2'd0, 1, 1);
        wait_done("err_a", 1, 3);
        step(0, 1, 2'd1, 0, 1);
        total++;
        if (err !== 1'b1 || pkt_vld !== 1'b0) begin
            bad++;
            $display("FAIL err_spike_in_done: got err=%b vld=%b want err=1 vld=0", err, pkt_vld);
        end
        do_reset();
        a0 = acc_cnt;
        step(1, 0, 2'd0, 0, 0);
        step(0, 1, 2'd0, 0, 0);
        step(0, 1, 2'd1, 0, 0);
        step(0, 0, 2'd0, 1, 0);
        step(1, 0, 2'd0, 0, 0);
        total++;
        if (err !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL err_tick_in_drain: got err=%b done=%b want err=1 done=0", err, done);
        end
        step(0, 1, 2'd3, 0, 0);
        step(0, 0, 2'd0, 1, 1);
        wait_done("err_b", 1, 10);
        total++;
        if (acc_cnt - a0 !== 3) begin
            bad++;
            $display("FAIL err_kept_pkts: got %0d want 3", acc_cnt - a0);
        end
    endtask

    task automatic test_random();
        do_reset();
        core_id = 4'($urandom_range(0, 15));
        for (int r = 0; r < 8; r++) begin
            step(1, 0, 2'd0, 0, 1'($urandom_range(0, 1)));
            for (int c = 0; c < 12; c++)
                step(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 0,
                     1'($urandom_range(0, 3) != 0));
            step(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1, 1'($urandom_range(0, 1)));
            for (int k = 0; k < 60 && !done; k++) step(0, 0, 2'd0, 0, 1'($urandom_range(0, 1)));
            total++;
            if (done !== 1'b1) begin
                bad++;
                $display("FAIL random_done: round %0d got %b want 1", r, done);
            end
        end
    endtask

    task automatic test_wrap_reset();
        do_reset();
        core_id = 4'd9;
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 2'd0, 0, 0);
            step(0, 0, 2'd0, 1, 0);
        end
        step(1, 0, 2'd0, 0, 0);
        step(0, 1, 2'd1, 0, 0);
        total++;
        if (pkt !== {4'd1, 4'd9, 2'd1}) begin
            bad++;
            $display("FAIL ts_wrap: got %h want %h", pkt, {4'd1, 4'd9, 2'd1});
        end
        for (int i = 0; i < 6; i++) step(0, 1, 2'(i), 0, 0);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({pkt_vld, done, ovf, err} !== 4'b0) begin
            bad++;
            $display("FAIL async_reset: got vld=%b done=%b ovf=%b err=%b want 0",
                     pkt_vld, done, ovf, err);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        step(0, 0, 2'd0, 0, 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_toggle();
        test_full_pushpop();
        test_errors();
        test_random();
        test_wrap_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
